// File: rtl/alu74181_wide_sequencer_if.sv
// rtl/alu74181_wide_sequencer_if.sv - request/result handshake bundle for the wide 74181 sequencer
// Ports: in_* operation request (valid/ready), out_* assembled result (valid/ready).
// master = producer of requests / consumer of results; slave = the sequencer.
interface alu74181_wide_sequencer_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [3:0]   in_s;
    logic         in_m;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_f;
    logic         out_cout;
    logic         out_eq;

    modport master (
        output in_valid, in_a, in_b, in_s, in_m, in_cin, out_ready,
        input  in_ready, out_valid, out_f, out_cout, out_eq
    );

    modport slave (
        input  in_valid, in_a, in_b, in_s, in_m, in_cin, out_ready,
        output in_ready, out_valid, out_f, out_cout, out_eq
    );
endinterface

// File: rtl/alu74181_wide_sequencer.sv
// rtl/alu74181_wide_sequencer.sv - runs a W-bit 74181 operation through one 4-bit slice, LS nibble first
// Ports: clk, rst_n (async, active-low); bus (slave modport: request in, result out);
// alu_a/alu_b/alu_s/alu_m/alu_notc drive the slice, alu_f/alu_cout/alu_eql come back from it.
module alu74181_wide_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    alu74181_wide_sequencer_if.slave    bus,
    output logic [3:0]                  alu_a,
    output logic [3:0]                  alu_b,
    output logic [3:0]                  alu_s,
    output logic                        alu_m,
    output logic                        alu_notc,
    input  logic [3:0]                  alu_f,
    input  logic                        alu_cout,
    input  logic                        alu_eql
);
    localparam int W    = 4 * NIBBLES;
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [3:0]      op_s;
    logic            op_m;
    logic [IDXW-1:0] idx;
    logic            carry_n;
    logic            eq_acc;
    logic [W-1:0]    res;

    logic            in_ready;
    logic            out_valid;
    logic            accept;
    logic [W-1:0]    a_shift;
    logic [W-1:0]    b_shift;
    logic [W-1:0]    f_placed;

    // Nibble selection by shifting keeps index arithmetic at its natural width.
    assign a_shift  = op_a >> {idx, 2'b00};
    assign b_shift  = op_b >> {idx, 2'b00};
    assign f_placed = W'(alu_f) << {idx, 2'b00};
    assign accept   = bus.in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_a      = 4'h0;
        alu_b      = 4'h0;
        alu_s      = 4'h0;
        alu_m      = 1'b1;
        alu_notc   = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                alu_a    = a_shift[3:0];
                alu_b    = b_shift[3:0];
                alu_s    = op_s;
                alu_m    = op_m;
                alu_notc = carry_n;
                if (idx == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            op_s    <= 4'h0;
            op_m    <= 1'b0;
            idx     <= '0;
            carry_n <= 1'b1;
            eq_acc  <= 1'b0;
            res     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a    <= bus.in_a;
                        op_b    <= bus.in_b;
                        op_s    <= bus.in_s;
                        op_m    <= bus.in_m;
                        idx     <= '0;
                        carry_n <= ~bus.in_cin;
                        eq_acc  <= 1'b1;
                        res     <= '0;
                    end
                end
                RUN: begin
                    // res was cleared on accept, so OR-ing each nibble into place suffices.
                    res     <= res | f_placed;
                    carry_n <= alu_cout;
                    eq_acc  <= eq_acc & alu_eql;
                    if (idx != LAST) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_f     = res;
    assign bus.out_cout  = ~carry_n;
    assign bus.out_eq    = eq_acc;
endmodule

// File: tb/tb_alu74181_wide_sequencer.sv
// tb/tb_alu74181_wide_sequencer.sv - directed bench for alu74181_wide_sequencer with a 74181 slice model
module tb_alu74181_wide_sequencer;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk;
    logic rst_n;
    logic [3:0] alu_a, alu_b, alu_s, alu_f;
    logic alu_m, alu_notc, alu_cout, alu_eql;

    int checks;
    int errors;

    alu74181_wide_sequencer_if #(.NIBBLES(NIBBLES)) bus ();

    alu74181_wide_sequencer #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_s    (alu_s),
        .alu_m    (alu_m),
        .alu_notc (alu_notc),
        .alu_f    (alu_f),
        .alu_cout (alu_cout),
        .alu_eql  (alu_eql)
    );

    // 74181 slice, active-high data: F = X plus Y plus carry (arith) or not(X xor Y) (logic).
    logic [3:0] sx, sy;
    logic [4:0] ssum;
    always_comb begin
        sx       = alu_a | (alu_b & {4{alu_s[0]}}) | (~alu_b & {4{alu_s[1]}});
        sy       = (alu_a & alu_b & {4{alu_s[3]}}) | (alu_a & ~alu_b & {4{alu_s[2]}});
        ssum     = {1'b0, sx} + {1'b0, sy} + {4'b0, ~alu_notc};
        alu_f    = alu_m ? ~(sx ^ sy) : ssum[3:0];
        alu_cout = ~ssum[4];
        alu_eql  = &alu_f;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and collects the result; returns lat=99 if out_valid never rose.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic cin, output int lat,
                          output logic [W-1:0] f, output logic cout, output logic eq,
                          output logic busy_ok);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b;
        bus.in_s = s; bus.in_m = m; bus.in_cin = cin;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        busy_ok = (bus.in_ready === 1'b0);
        lat = 99;
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        f = bus.out_f; cout = bus.out_cout; eq = bus.out_eq;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_cout !== 1'b0 || bus.out_eq !== 1'b0) begin errors++; $display("FAIL reset_flags got cout=%b eq=%b want 0 0", bus.out_cout, bus.out_eq); end
        checks++; if ({alu_a, alu_b, alu_s, alu_m, alu_notc} !== {12'h000, 1'b1, 1'b1}) begin errors++; $display("FAIL reset_alu_idle got a=%h b=%h s=%h m=%b nc=%b", alu_a, alu_b, alu_s, alu_m, alu_notc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_add;
        int lat; logic [W-1:0] f; logic c, e, bz;
        run_op(16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (bz !== 1'b1) begin errors++; $display("FAIL add_in_ready_busy got in_ready high want low"); end
        checks++; if (f !== 16'h0100 || c !== 1'b0) begin errors++; $display("FAIL add_carry got f=%h cout=%b want 0100 0", f, c); end
        run_op(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (f !== 16'h0000 || c !== 1'b1) begin errors++; $display("FAIL add_wrap got f=%h cout=%b want 0000 1", f, c); end
    endtask

    task automatic test_sub;
        int lat; logic [W-1:0] f; logic c, e, bz;
        run_op(16'h1234, 16'h0234, 4'b0110, 1'b0, 1'b1, lat, f, c, e, bz);
        checks++; if (f !== 16'h1000 || c !== 1'b1) begin errors++; $display("FAIL sub_cin1 got f=%h cout=%b want 1000 1", f, c); end
        run_op(16'h1234, 16'h0234, 4'b0110, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (f !== 16'h0FFF || c !== 1'b1) begin errors++; $display("FAIL sub_cin0 got f=%h cout=%b want 0fff 1", f, c); end
    endtask

    task automatic test_equality;
        int lat; logic [W-1:0] f; logic c, e, bz;
        run_op(16'hBEEF, 16'hBEEF, 4'b0110, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (f !== 16'hFFFF || e !== 1'b1 || c !== 1'b0) begin errors++; $display("FAIL eq_same got f=%h eq=%b cout=%b want ffff 1 0", f, e, c); end
        run_op(16'hBEEF, 16'hBEEE, 4'b0110, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (f !== 16'h0000 || e !== 1'b0) begin errors++; $display("FAIL eq_diff got f=%h eq=%b want 0000 0", f, e); end
    endtask

    task automatic test_logic_backpressure;
        int n; logic [W-1:0] f0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 16'hF0F0; bus.in_b = 16'hFF00;
        bus.in_s = 4'b0110; bus.in_m = 1'b1; bus.in_cin = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_f !== 16'h0FF0) begin errors++; $display("FAIL logic_xor got valid=%b f=%h want 1 0ff0", bus.out_valid, bus.out_f); end
        f0 = 16'h0FF0;
        // Second request offered during the stall must not be taken.
        bus.in_valid = 1'b1; bus.in_a = 16'h1111; bus.in_b = 16'h2222; bus.in_m = 1'b0; bus.in_s = 4'b1001;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_f !== f0 || bus.in_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold cycle %0d got valid=%b f=%h in_ready=%b want 1 %h 0", k, bus.out_valid, bus.out_f, bus.in_ready, f0);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
        @(posedge clk); #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_no_accept got in_ready=%b want 1", bus.in_ready); end
    endtask

    task automatic test_reset_mid_run;
        int lat; logic [W-1:0] f; logic c, e, bz;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_a = 16'hFFFF; bus.in_b = 16'hFFFF;
        bus.in_s = 4'b1001; bus.in_m = 1'b0; bus.in_cin = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_idle got in_ready=%b valid=%b want 1 0", bus.in_ready, bus.out_valid); end
        run_op(16'h0001, 16'h0001, 4'b1001, 1'b0, 1'b0, lat, f, c, e, bz);
        checks++; if (lat !== 4 || f !== 16'h0002 || c !== 1'b0) begin errors++; $display("FAIL midrst_next got lat=%0d f=%h cout=%b want 4 0002 0", lat, f, c); end
    endtask

    initial begin
        checks = 0; errors = 0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_s = 4'h0;
        bus.in_m = 1'b0; bus.in_cin = 1'b0; bus.out_ready = 1'b0;
        test_reset;
        test_add;
        test_sub;
        test_equality;
        test_logic_backpressure;
        test_reset_mid_run;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu74181_wide_sequencer.md
Name: alu74181_wide_sequencer

Overview:
- Upstream controller for the 4-bit ALU74181 slice.
- Accepts one wide operation (two NIBBLES×4-bit operands, S/M select, carry-in) over a valid/ready handshake.
- Feeds it to a single ALU74181 one nibble per cycle, least significant nibble first, rippling the carry through a register. Consumes the slice's F/Cn+4/A=B, assembles the wide result and presents it on a valid/ready output.
- Lets one TinyTapeout tile run 16-bit ALU operations with one 74181 slice.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operation; operand width W = 4*NIBBLES; must be ≥ 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operation request
- in_ready  out  1  high only in IDLE
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_s  in  4  74181 function select
- in_m  in  1  1=logic, 0=arithmetic
- in_cin  in  1  carry-in, active-high, i.e. +1 in arithmetic mode
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_f  out  W  assembled result
- out_cout  out  1  carry-out of top nibble, active-high
- out_eq  out  1  AND of A=B over all nibbles
- alu_a  out  4  to slice A
- alu_b  out  4  to slice B
- alu_s  out  4  to slice S
- alu_m  out  1  to slice M
- alu_notc  out  1  to slice Cn, active-low
- alu_f  in  4  from slice F
- alu_cout  in  1  from slice Cn+4, active-low
- alu_eql  in  1  from slice A=B

Behaviour:
- State machine states:
  - IDLE: in_ready=1.
    - On in_valid&&in_ready, capture in_a, in_b, in_s, in_m and in_cin.
    - Set idx=0 and carry_n=~in_cin. Clear the result register, set eq_acc=1, go to RUN.
  - RUN: combinationally drive the slice from the captured fields.
    - alu_a=opA[4*idx+:4], alu_b=opB[4*idx+:4], alu_s=S, alu_m=M, alu_notc=carry_n.
    - Each clock edge: res[4*idx+:4]<=alu_f; carry_n<=alu_cout; eq_acc<=eq_acc&alu_eql; idx<=idx+1.
    - At idx==NIBBLES-1 go to DONE instead of incrementing.
  - DONE: out_valid=1; out_f=res; out_cout=~carry_n; out_eq=eq_acc.
    - Hold all outputs stable until out_ready. On out_valid&&out_ready go to IDLE.
- Carry rules:
  - In M=1 the slice ignores Cn, but carry_n is still captured each cycle.
  - out_cout is then whatever the slice reports and carries no meaning.
- Latency: out_valid rises exactly NIBBLES clock edges after the accepting edge.
  - Throughput is one operation per NIBBLES+2 cycles minimum: accept, RUN×N, DONE handshake.
  - in_ready is 0 from the accepting edge until DONE is left. No overlap.
- alu_* in IDLE/DONE: alu_a=alu_b=0, alu_s=0, alu_m=1, alu_notc=1. The slice output is ignored there.
- Backpressure: out_ready low in DONE holds the state indefinitely. in_valid is ignored while in_ready=0.
- out_f/out_cout/out_eq are valid only while out_valid=1. Outside DONE they hold last-registered values.
- Reset (any time, including mid-RUN) forces:
  - state=IDLE, idx=0, res=0, carry_n=1, eq_acc=0;
  - out_valid=0, in_ready=1 after reset deasserts, out_cout=0, out_eq=0.
  - The in-flight operation is discarded and no partial result is emitted.
- idx width: clog2(NIBBLES), minimum 1 bit. idx never exceeds NIBBLES-1.
- NIBBLES=1: RUN lasts one cycle. Behaviour is identical to a registered single slice.

Test Plan (NIBBLES=4, bench instantiates ALU74181 as the slice):
- Add with internal carry: A=0x00FF, B=0x0001, S=1001, M=0, cin=0 → out_f=0x0100, out_cout=0; out_valid 4 edges after accept.
- Add with wrap-around: A=0xFFFF, B=0x0001, S=1001, M=0, cin=0 → out_f=0x0000, out_cout=1.
- Subtract: A=0x1234, B=0x0234, S=0110, M=0, cin=1 → out_f=0x1000, out_cout=1.
  - Same operation with cin=0 → out_f=0x0FFF.
- Equality: A=B=0xBEEF, S=0110, M=0, cin=0 → out_f=0xFFFF, out_eq=1.
  - A=0xBEEF, B=0xBEEE → out_eq=0.
- Logic and backpressure: A=0xF0F0, B=0xFF00, S=0110, M=1 → out_f=0x0FF0.
  - Hold out_ready=0 for 5 cycles: out_valid and out_f stay stable, in_ready stays 0.
  - A second in_valid during the stall is not accepted.
- Reset mid-operation: assert rst_n=0 after 2 RUN edges → out_valid=0, in_ready=1 after release.
  - Next operation 0x0001+0x0001 → out_f=0x0002, with no residue from the aborted operation.
